// File: rtl/key_sched_pkg.sv
// Shared types and constants for the nibble-serial Mini-AES key schedule.
package key_sched_pkg;

  localparam int unsigned NIB_W = 4;
  localparam logic [NIB_W-1:0] RCON_INIT = 4'h1;

  typedef enum logic [1:0] {
    LOAD,
    EMIT,
    EXPAND
  } state_t;

  localparam logic [NIB_W-1:0] SBOX [16] = '{
    4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
    4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
  };

  // Multiply by x in GF(2^4) modulo x^4+x+1.
  function automatic logic [NIB_W-1:0] xtime(input logic [NIB_W-1:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

endpackage

// File: rtl/key_sched_stream_sbox.sv
// Mini-AES 4-bit S-box, purely combinational.
module mini_sbox
  import key_sched_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [NIB_W-1:0] sub
);

  always_comb begin
    sub = SBOX[nib];
  end

endmodule

// File: rtl/key_sched_stream.sv
// Nibble-serial Mini-AES key schedule: loads a 16-bit key, streams ROUNDS+1 round keys MSN first.
// Optional K0 replay from a shadow register when KEY_SCHED_REPLAY_EN is defined.
module key_sched_stream
  import key_sched_pkg::*;
#(
  parameter int unsigned ROUNDS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NIB_W-1:0] key_nib_in,
  input  logic             key_valid_in,
  output logic             key_ready_out,
  output logic [NIB_W-1:0] rk_nib_out,
  output logic             rk_valid_out,
  input  logic             rk_ready_in,
  output logic             rk_last_out,
  input  logic             replay_in,
  output logic             busy_out
);

  localparam int unsigned RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS);

  state_t           state, state_nxt;
  logic [NIB_W-1:0] w0, w1, w2, w3;
  logic [NIB_W-1:0] w0_nxt, w1_nxt, w2_nxt, w3_nxt;
  logic [NIB_W-1:0] sw3;
  logic [NIB_W-1:0] rcon;
  logic [1:0]       beat;
  logic [RW-1:0]    round;
  logic             key_beat, rk_beat, replay_go;
  logic [15:0]      reload_key;

  mini_sbox u_sbox (
    .nib (w3),
    .sub (sw3)
  );

`ifdef KEY_SCHED_REPLAY_EN
  logic [15:0] shadow;
  logic        shadow_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      shadow_vld <= 1'b0;
    end else if (key_beat && beat == 2'd3) begin
      shadow     <= {w1, w2, w3, key_nib_in};
      shadow_vld <= 1'b1;
    end
  end

  assign replay_go  = (state == LOAD) && replay_in && shadow_vld;
  assign reload_key = shadow;
`else
  logic unused_replay;
  assign unused_replay = replay_in;
  assign replay_go     = 1'b0;
  assign reload_key    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Replay takes priority over a key nibble by withholding key_ready_out.
  always_comb begin
    state_nxt     = state;
    key_ready_out = 1'b0;
    rk_valid_out  = 1'b0;
    case (state)
      LOAD: begin
        key_ready_out = !replay_go;
        if (replay_go)                        state_nxt = EMIT;
        else if (key_valid_in && beat == 2'd3) state_nxt = EMIT;
      end
      EMIT: begin
        rk_valid_out = 1'b1;
        if (rk_ready_in && beat == 2'd3)
          state_nxt = (round == ROUND_LAST) ? LOAD : EXPAND;
      end
      EXPAND:  state_nxt = EMIT;
      default: state_nxt = LOAD;
    endcase
  end

  assign key_beat = key_valid_in && key_ready_out;
  assign rk_beat  = rk_valid_out && rk_ready_in;

  always_comb begin
    w0_nxt = w0 ^ sw3 ^ rcon;
    w1_nxt = w1 ^ w0_nxt;
    w2_nxt = w2 ^ w1_nxt;
    w3_nxt = w3 ^ w2_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      beat  <= '0;
      round <= '0;
      rcon  <= '0;
    end else if (replay_go) begin
      {w0, w1, w2, w3} <= reload_key;
      beat  <= '0;
      round <= '0;
      rcon  <= RCON_INIT;
    end else if (key_beat) begin
      w0   <= w1;
      w1   <= w2;
      w2   <= w3;
      w3   <= key_nib_in;
      beat <= beat + 2'd1;
      if (beat == 2'd3) begin
        round <= '0;
        rcon  <= RCON_INIT;
      end
    end else if (rk_beat) begin
      beat <= beat + 2'd1;
    end else if (state == EXPAND) begin
      w0    <= w0_nxt;
      w1    <= w1_nxt;
      w2    <= w2_nxt;
      w3    <= w3_nxt;
      round <= round + RW'(1);
      rcon  <= xtime(rcon);
    end
  end

  always_comb begin
    rk_nib_out = '0;
    if (state == EMIT) begin
      case (beat)
        2'd0:    rk_nib_out = w0;
        2'd1:    rk_nib_out = w1;
        2'd2:    rk_nib_out = w2;
        default: rk_nib_out = w3;
      endcase
    end
  end

  assign rk_last_out = (state == EMIT) && (round == ROUND_LAST) && (beat == 2'd3);
  assign busy_out    = (state != LOAD);

endmodule

// File: tb/tb_key_sched_stream.sv
// Scoreboard bench for key_sched_stream; replay steps compile in with KEY_SCHED_REPLAY_EN.
module tb_key_sched_stream;

  localparam int unsigned ROUNDS = 2;
  localparam logic [3:0] SB [16] = '{
    4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
    4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_nib_in = '0;
  logic       key_valid_in = 1'b0;
  logic       key_ready_out;
  logic [3:0] rk_nib_out;
  logic       rk_valid_out;
  logic       rk_ready_in = 1'b0;
  logic       rk_last_out;
  logic       replay_in = 1'b0;
  logic       busy_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_beats = 0;
  logic [4:0] exp_q[$];
  int         cyc_q[$];

  key_sched_stream #(.ROUNDS(ROUNDS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_nib_in    (key_nib_in),
    .key_valid_in  (key_valid_in),
    .key_ready_out (key_ready_out),
    .rk_nib_out    (rk_nib_out),
    .rk_valid_out  (rk_valid_out),
    .rk_ready_in   (rk_ready_in),
    .rk_last_out   (rk_last_out),
    .replay_in     (replay_in),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {last, nibble} sequence for one key, built from the S-box table and xtime.
  function automatic void push_model(input logic [15:0] k);
    logic [3:0] w [4];
    logic [3:0] rc;
    rc = 4'h1;
    for (int i = 0; i < 4; i++) w[i] = k[15-4*i -: 4];
    for (int unsigned r = 0; r <= ROUNDS; r++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({(r == ROUNDS && i == 3), w[i]});
      w[0] = w[0] ^ SB[w[3]] ^ rc;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = {rc[2:0], 1'b0} ^ (rc[3] ? 4'h3 : 4'h0);
    end
  endfunction

  // Output monitor: pops the scoreboard on each rk beat and checks stall stability.
  initial begin
    logic       prev_stall;
    logic [3:0] prev_nib;
    logic       prev_last;
    logic [4:0] e;
    prev_stall = 1'b0;
    prev_nib   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(rk_valid_out), 32'(1'b1));
          check("stall_nib", 32'(rk_nib_out), 32'(prev_nib));
          check("stall_last", 32'(rk_last_out), 32'(prev_last));
        end
        if (busy_out) check("ready_low_busy", 32'(key_ready_out), 32'(1'b0));
        if (rk_valid_out && rk_ready_in) begin
          n_beats++;
          cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(exp_q.size()), 32'(1));
          end else begin
            e = exp_q.pop_front();
            check("rk_nib", 32'(rk_nib_out), 32'(e[3:0]));
            check("rk_last", 32'(rk_last_out), 32'(e[4]));
          end
        end
        prev_stall = rk_valid_out && !rk_ready_in;
        prev_nib   = rk_nib_out;
        prev_last  = rk_last_out;
      end
    end
  end

  task automatic load_key(input logic [15:0] k);
    for (int i = 0; i < 4; i++) begin
      check("key_ready_load", 32'(key_ready_out), 32'(1'b1));
      key_nib_in   = k[15-4*i -: 4];
      key_valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    key_valid_in = 1'b0;
    check("latency_valid", 32'(rk_valid_out), 32'(1'b1));
  endtask

  task automatic run_stream(input bit bp);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      if (bp) begin
        rk_ready_in  = 1'($urandom_range(0, 1));
        key_valid_in = 1'($urandom_range(0, 1));
        key_nib_in   = 4'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    key_valid_in = 1'b0;
    rk_ready_in  = 1'b1;
    check("stream_done", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic end_check();
    @(negedge clk);
    check("post_key_ready", 32'(key_ready_out), 32'(1'b1));
    check("post_busy", 32'(busy_out), 32'(1'b0));
    check("post_valid", 32'(rk_valid_out), 32'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key_ready", 32'(key_ready_out), 32'(1'b1));
    check("rst_valid", 32'(rk_valid_out), 32'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_key_ready_rel", 32'(key_ready_out), 32'(1'b1));
    check("rst_valid_rel", 32'(rk_valid_out), 32'(1'b0));
    check("rst_last", 32'(rk_last_out), 32'(1'b0));
    check("rst_busy", 32'(busy_out), 32'(1'b0));
    check("rst_nib", 32'(rk_nib_out), 32'(4'h0));
    @(posedge clk);
    #1;

    // C3F0 full rate, with beat spacing check
    rk_ready_in = 1'b1;
    cyc_q.delete();
    push_model(16'hC3F0);
    load_key(16'hC3F0);
    run_stream(1'b0);
    check("beat_count", 32'(cyc_q.size()), 32'(12));
    if (cyc_q.size() >= 12)
      for (int i = 1; i < 12; i++)
        check("beat_gap", 32'(cyc_q[i] - cyc_q[i-1]), (i % 4 == 0) ? 32'(2) : 32'(1));
    end_check();

    // All-zero key
    push_model(16'h0000);
    load_key(16'h0000);
    run_stream(1'b0);
    end_check();

    // Backpressure with stray key_valid_in during emission
    push_model(16'hC3F0);
    load_key(16'hC3F0);
    run_stream(1'b1);
    end_check();

    // Reset after the 6th rk beat, then reload
    push_model(16'hC3F0);
    base = n_beats;
    load_key(16'hC3F0);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      if (n_beats >= base + 6) break;
    end
    #1;
    check("mid_reset_reached", 32'(n_beats - base), 32'(6));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy_out), 32'(1'b0));
    check("mid_rst_valid", 32'(rk_valid_out), 32'(1'b0));
    check("mid_rst_ready", 32'(key_ready_out), 32'(1'b1));
    check("mid_rst_nib", 32'(rk_nib_out), 32'(4'h0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_model(16'h0000);
    load_key(16'h0000);
    run_stream(1'b0);
    end_check();

`ifdef KEY_SCHED_REPLAY_EN
    push_model(16'hC3F0);
    load_key(16'hC3F0);
    run_stream(1'b0);
    end_check();

    push_model(16'hC3F0);
    replay_in = 1'b1;
    @(posedge clk);
    #1;
    replay_in = 1'b0;
    check("replay_valid", 32'(rk_valid_out), 32'(1'b1));
    run_stream(1'b0);
    end_check();

    push_model(16'hC3F0);
    replay_in    = 1'b1;
    key_valid_in = 1'b1;
    key_nib_in   = 4'h5;
    @(negedge clk);
    check("replay_wins_ready", 32'(key_ready_out), 32'(1'b0));
    @(posedge clk);
    #1;
    replay_in    = 1'b0;
    key_valid_in = 1'b0;
    check("replay_wins_valid", 32'(rk_valid_out), 32'(1'b1));
    run_stream(1'b0);
    end_check();
`else
    replay_in = 1'b1;
    @(negedge clk);
    check("replay_ignored_ready", 32'(key_ready_out), 32'(1'b1));
    @(posedge clk);
    #1;
    replay_in = 1'b0;
    @(negedge clk);
    check("replay_ignored_busy", 32'(busy_out), 32'(1'b0));
    check("replay_ignored_valid", 32'(rk_valid_out), 32'(1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
